// File: rtl/rv_alu.sv
// rv_alu: registered integer ALU for the execute stage.
// Performs AND / OR / ADD / SUB on two unsigned operands with a one-cycle
// latency. The result, its zero flag and a valid bit all leave the block
// straight from flops, so downstream logic never sees combinational glitches.
//
// Handshake: in_valid qualifies in_a/in_b/alu_op on the cycle it is high;
// there is no ready, so the block accepts one operation every cycle.
// out_valid is in_valid delayed by one edge. On bubble cycles
// (in_valid == 0) result and zero keep their last values and out_valid drops.
module rv_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             out_valid
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    logic [WIDTH-1:0] op_result;
    logic [WIDTH-1:0] result_d, result_q;
    logic             zero_d, zero_q;
    logic             out_valid_d, out_valid_q;

    // Operation datapath; unknown opcodes produce a clean zero, never X.
    always_comb begin
        op_result = '0;
        case (alu_op)
            OP_AND:  op_result = in_a & in_b;
            OP_OR:   op_result = in_a | in_b;
            OP_ADD:  op_result = in_a + in_b;   // carry-out dropped
            OP_SUB:  op_result = in_a - in_b;   // borrow dropped
            default: op_result = '0;
        endcase
    end

    // Next-state: capture a new result on valid cycles, hold on bubbles.
    // zero is derived from the value being registered so it always matches.
    always_comb begin
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            result_d = op_result;
            zero_d   = (op_result == '0);
        end
    end

    // Output registers; reset puts result=0 / zero=1 so the flag stays consistent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rv_alu.sv
// tb_rv_alu: self-checking bench for rv_alu.
// Directed vector table, hand-written hold and reset sequences, and a random
// back-to-back stream compared against a plain-arithmetic reference model.
module tb_rv_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [3:0]   alu_op = 4'b0000;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [W-1:0] result;
    logic         zero;
    logic         out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    // coverage: [op index 0..3][observed zero]
    int cov [4][2];

    rv_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .alu_op    (alu_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .result    (result),
        .zero      (zero),
        .out_valid (out_valid)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: arithmetic on wide unsigned integers, reduced mod 2^W.
    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint unsigned ua, ub, m;
        ua = longint'(a);
        ub = longint'(b);
        m  = 64'h1_0000_0000;
        case (op)
            4'b0000: ref_alu = a & b;
            4'b0001: ref_alu = a | b;
            4'b0010: ref_alu = W'((ua + ub) % m);
            4'b0110: ref_alu = W'((ua + m - ub) % m);
            default: ref_alu = '0;
        endcase
    endfunction

    function automatic int op_idx(input logic [3:0] op);
        case (op)
            4'b0000: op_idx = 0;
            4'b0001: op_idx = 1;
            4'b0010: op_idx = 2;
            4'b0110: op_idx = 3;
            default: op_idx = -1;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        in_valid = v;
        alu_op   = op;
        in_a     = a;
        in_b     = b;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_r;
        logic         exp_z;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input string name, input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] r, input logic z);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.exp_r = r; v.exp_z = z;
        return v;
    endfunction

    // ---------------- scoreboard for random stream ----------------
    // entry = {valid, zero, result}
    logic [W+1:0] exp_q[$];
    logic [3:0]   op_q[$];
    logic [W-1:0] mdl_r;
    logic         mdl_z;

    initial begin
        logic [3:0]   op;
        logic [W-1:0] a, b, r;
        logic         v;
        logic [W+1:0] e;
        logic [3:0]   eop;
        logic [3:0]   ops[6];
        ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110;
        ops[4] = 4'b1111; ops[5] = 4'b1010;
        for (int i = 0; i < 4; i++) begin cov[i][0] = 0; cov[i][1] = 0; end

        // ---- reset state ----
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_result", result, '0);
        check("reset_zero", W'(zero), W'(1'b1));
        check("reset_out_valid", W'(out_valid), W'(1'b0));
        rst_n = 1'b1;

        // ---- random back-to-back stream ----
        mdl_r = '0;
        mdl_z = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                eop = op_q.pop_front();
                check("stream_result", result, e[W-1:0]);
                check("stream_zero", W'(zero), W'(e[W]));
                check("stream_out_valid", W'(out_valid), W'(e[W+1]));
                if (e[W+1] && op_idx(eop) >= 0 && zero === e[W])
                    cov[op_idx(eop)][zero]++;
            end
            v  = ($urandom_range(0, 7) != 0);
            op = ($urandom_range(0, 15) == 0) ? ops[4 + $urandom_range(0, 1)]
                                               : ops[$urandom_range(0, 3)];
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 5) == 0) begin
                // steer operands toward a zero result
                case (op)
                    4'b0000: b = ~a;
                    4'b0001: begin a = '0; b = '0; end
                    4'b0010: b = W'(0) - a;
                    default: b = a;
                endcase
            end
            drive(v, op, a, b);
            if (v) begin
                mdl_r = ref_alu(op, a, b);
                mdl_z = (mdl_r == 0);
            end
            exp_q.push_back({v, mdl_z, mdl_r});
            op_q.push_back(op);
        end
        @(negedge clk);
        e = exp_q.pop_front();
        eop = op_q.pop_front();
        check("stream_last_result", result, e[W-1:0]);
        check("stream_last_out_valid", W'(out_valid), W'(e[W+1]));

        for (int i = 0; i < 4; i++) begin
            for (int z = 0; z < 2; z++) begin
                n_cmp++;
                if (cov[i][z] == 0) begin
                    n_bad++;
                    $display("FAIL coverage op%0d zero=%0d: hits 0, required >0", i, z);
                end
            end
        end

        // ---- directed table ----
        vq.push_back(mk("and_mix",    4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0));
        vq.push_back(mk("or_zero",    4'b0001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1));
        vq.push_back(mk("or_mix",     4'b0001, 32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A, 1'b0));
        vq.push_back(mk("add_small",  4'b0010, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0));
        vq.push_back(mk("add_wrap",   4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1));
        vq.push_back(mk("add_ovf",    4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0));
        vq.push_back(mk("sub_eq",     4'b0110, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1));
        vq.push_back(mk("sub_borrow", 4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0));
        vq.push_back(mk("sub_min",    4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0));
        vq.push_back(mk("inv_1111",   4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 1'b1));
        vq.push_back(mk("or_nz",      4'b0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0));
        vq.push_back(mk("inv_1100",   4'b1100, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 1'b1));
        vq.push_back(mk("add_nz",     4'b0010, 32'h0000_0002, 32'h0000_0002, 32'h0000_0004, 1'b0));
        vq.push_back(mk("inv_1010",   4'b1010, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 1'b1));

        @(negedge clk);
        foreach (vq[i]) begin
            drive(1'b1, vq[i].op, vq[i].a, vq[i].b);
            @(negedge clk);
            check({vq[i].name, "_result"}, result, vq[i].exp_r);
            check({vq[i].name, "_zero"}, W'(zero), W'(vq[i].exp_z));
            check({vq[i].name, "_out_valid"}, W'(out_valid), W'(1'b1));
        end

        // ---- hold on bubbles ----
        drive(1'b1, 4'b0010, 32'h0000_0005, 32'h0000_0003);
        @(negedge clk);
        check("hold_pre_result", result, 32'h0000_0008);
        drive(1'b0, 4'b0110, 32'h0000_0009, 32'h0000_0009);
        @(negedge clk);
        check("hold_result", result, 32'h0000_0008);
        check("hold_zero", W'(zero), W'(1'b0));
        check("hold_out_valid", W'(out_valid), W'(1'b0));
        drive(1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h1234_5678);
        @(negedge clk);
        check("hold2_result", result, 32'h0000_0008);
        check("hold2_out_valid", W'(out_valid), W'(1'b0));

        // ---- asynchronous reset mid-stream ----
        drive(1'b1, 4'b0001, 32'hA5A5_0000, 32'h0000_5A5A);
        @(negedge clk);
        check("prerst_result", result, 32'hA5A5_5A5A);
        check("prerst_out_valid", W'(out_valid), W'(1'b1));
        drive(1'b1, 4'b0010, 32'h0000_0001, 32'h0000_0002);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_result", result, '0);
        check("async_rst_zero", W'(zero), W'(1'b1));
        check("async_rst_out_valid", W'(out_valid), W'(1'b0));
        @(posedge clk);
        #1;
        check("rst_held_result", result, '0);
        check("rst_held_out_valid", W'(out_valid), W'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'b0110, 32'h0000_0000, 32'h0000_0001);
        @(negedge clk);
        check("post_rst_result", result, 32'hFFFF_FFFF);
        check("post_rst_zero", W'(zero), W'(1'b0));
        check("post_rst_out_valid", W'(out_valid), W'(1'b1));
        drive(1'b0, 4'b0000, '0, '0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
